id_ctrl_sequencer: RTL and testbench

Decode-stage controller for the pipelined RV32I core. It holds the fetched instruction in the IF/ID slot and drives the ImmSrc select combinationally into the immediate extender. It decodes the main control bundle and issues it through a valid/ready ID/EX register. It also inserts load-use bubbles, traps illegal opcodes and handles branch flushes.

---
 rtl/id_ctrl_sequencer_if.sv | 46 ++++
 rtl/id_ctrl_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_id_ctrl_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ctrl_sequencer_if.sv
// Decode-stage bus bundle: fetch-side handshake, flush, the combinational
// ImmSrc select and the registered ID/EX control bundle toward EX.
interface id_ctrl_sequencer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // Fetch side
    logic [DATA_WIDTH-1:0]     instr_i;
    logic                      instr_valid_i;
    logic                      instr_ready_o;
    logic                      flush_i;

    // Combinational select into the immediate extender
    logic [2:0]                ImmSrc;

    // ID/EX register toward EX
    logic                      ctrl_valid_o;
    logic                      ctrl_ready_i;
    logic                      RegWriteE;
    logic                      MemWriteE;
    logic                      ALUSrcE;
    logic                      BranchE;
    logic                      JumpE;
    logic [1:0]                ResultSrcE;
    logic [2:0]                ImmSrcE;
    logic [REG_ADDR_WIDTH-1:0] Rs1E;
    logic [REG_ADDR_WIDTH-1:0] Rs2E;
    logic [REG_ADDR_WIDTH-1:0] RdE;
    logic                      illegal_o;

    // Sequencer side
    modport slave (
        input  instr_i, instr_valid_i, flush_i, ctrl_ready_i,
        output instr_ready_o, ImmSrc, ctrl_valid_o,
               RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
               ResultSrcE, ImmSrcE, Rs1E, Rs2E, RdE, illegal_o
    );

    // Environment side (fetch stage, EX stage, test drivers)
    modport master (
        output instr_i, instr_valid_i, flush_i, ctrl_ready_i,
        input  instr_ready_o, ImmSrc, ctrl_valid_o,
               RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
               ResultSrcE, ImmSrcE, Rs1E, Rs2E, RdE, illegal_o
    );
endinterface

// File: rtl/id_ctrl_sequencer.sv
// Decode-stage controller for the pipelined RV32I core.
// Holds one fetched word in the D slot, decodes the main control bundle,
// issues it through a valid/ready ID/EX register, inserts load-use bubbles,
// traps illegal opcodes and kills both stages on a branch flush.
module id_ctrl_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    id_ctrl_sequencer_if.slave   bus
);

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ResultSrc encoding of a load; used by the load-use detector
    localparam logic [1:0] RES_MEM    = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        TRAP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     instr_q, instr_d;

    logic                      ctrl_valid_q, ctrl_valid_d;
    logic                      reg_write_q, reg_write_d;
    logic                      mem_write_q, mem_write_d;
    logic                      alu_src_q, alu_src_d;
    logic                      branch_q, branch_d;
    logic                      jump_q, jump_d;
    logic [1:0]                result_src_q, result_src_d;
    logic [2:0]                imm_src_q, imm_src_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;

    // ------------------------------------------------------------------
    // Fields of the held instruction
    // ------------------------------------------------------------------
    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1_f;
    logic [REG_ADDR_WIDTH-1:0] rs2_f;
    logic [REG_ADDR_WIDTH-1:0] rd_f;

    assign opcode = instr_q[6:0];
    assign rd_f   = instr_q[7 +: REG_ADDR_WIDTH];
    assign rs1_f  = instr_q[15 +: REG_ADDR_WIDTH];
    assign rs2_f  = instr_q[20 +: REG_ADDR_WIDTH];

    // funct3/funct7 do not influence the main control bundle
    logic unused_funct;
    assign unused_funct = ^{instr_q[DATA_WIDTH-1:25], instr_q[14:12]};

    // ------------------------------------------------------------------
    // Main decoder
    // ------------------------------------------------------------------
    logic       dec_legal;
    logic       dec_use_rs1;
    logic       dec_use_rs2;
    logic       dec_reg_write;
    logic       dec_mem_write;
    logic       dec_alu_src;
    logic       dec_branch;
    logic       dec_jump;
    logic [1:0] dec_result_src;
    logic [2:0] dec_imm_src;

    // Opcode -> control bundle; unknown opcodes (including any word whose
    // low two bits are not 11) fall into the default and are flagged illegal.
    always_comb begin
        dec_legal      = 1'b1;
        dec_use_rs1    = 1'b1;
        dec_use_rs2    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_result_src = 2'b00;
        dec_imm_src    = 3'b000;
        case (opcode)
            OPC_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b01;
                dec_alu_src    = 1'b1;
            end
            OPC_OPIMM: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
            end
            OPC_JALR: begin
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b10;
                dec_alu_src    = 1'b1;
                dec_jump       = 1'b1;
            end
            OPC_STORE: begin
                dec_imm_src    = 3'b001;
                dec_mem_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_use_rs2    = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm_src    = 3'b010;
                dec_branch     = 1'b1;
                dec_use_rs2    = 1'b1;
            end
            OPC_JAL: begin
                dec_imm_src    = 3'b100;
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b10;
                dec_jump       = 1'b1;
                dec_use_rs1    = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm_src    = 3'b101;
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_use_rs1    = 1'b0;
            end
            OPC_OP: begin
                dec_reg_write  = 1'b1;
                dec_use_rs2    = 1'b1;
            end
            default: begin
                dec_legal      = 1'b0;
                dec_use_rs1    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and hazard logic
    // ------------------------------------------------------------------
    logic hazard;
    logic idex_free;
    logic issue;
    logic instr_ready;
    logic accept;

    // Load in EX whose destination is a source of the held instruction.
    // x0 is never a real dependency.
    assign hazard = ctrl_valid_q && (result_src_q == RES_MEM) && (rd_q != '0) &&
                    ((dec_use_rs1 && (rs1_f == rd_q)) ||
                     (dec_use_rs2 && (rs2_f == rd_q)));

    // ID/EX can take a new entry when empty or being drained by EX this cycle
    assign idex_free = !ctrl_valid_q || bus.ctrl_ready_i;

    assign issue = (state_q == HOLD) && dec_legal && !hazard && idex_free;

    // The D slot accepts when empty or when its occupant leaves this cycle;
    // a flush or an active reset blocks any transfer.
    assign instr_ready = rst_n && !bus.flush_i &&
                         ((state_q == IDLE) || ((state_q == HOLD) && issue));

    assign accept = bus.instr_valid_i && instr_ready;

    // D-slot sequencing: flush wins, an illegal word parks in TRAP until flushed
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        if (accept) begin
            instr_d = bus.instr_i;
        end
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!dec_legal) begin
                        state_d = TRAP;
                    end else if (issue) begin
                        state_d = accept ? HOLD : IDLE;
                    end
                end
                TRAP: begin
                    state_d = TRAP;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ID/EX next value: flush -> bubble, issue -> new bundle,
    // free but nothing to issue -> bubble, stalled by EX -> hold
    always_comb begin
        ctrl_valid_d = ctrl_valid_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        alu_src_d    = alu_src_q;
        branch_d     = branch_q;
        jump_d       = jump_q;
        result_src_d = result_src_q;
        imm_src_d    = imm_src_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        if (bus.flush_i || (idex_free && !issue)) begin
            ctrl_valid_d = 1'b0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            alu_src_d    = 1'b0;
            branch_d     = 1'b0;
            jump_d       = 1'b0;
            result_src_d = 2'b00;
            imm_src_d    = 3'b000;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
        end else if (issue) begin
            ctrl_valid_d = 1'b1;
            reg_write_d  = dec_reg_write;
            mem_write_d  = dec_mem_write;
            alu_src_d    = dec_alu_src;
            branch_d     = dec_branch;
            jump_d       = dec_jump;
            result_src_d = dec_result_src;
            imm_src_d    = dec_imm_src;
            rs1_d        = rs1_f;
            rs2_d        = rs2_f;
            rd_d         = rd_f;
        end
    end

    // D-slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_valid_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            result_src_q <= 2'b00;
            imm_src_q    <= 3'b000;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
        end else begin
            ctrl_valid_q <= ctrl_valid_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            result_src_q <= result_src_d;
            imm_src_q    <= imm_src_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.instr_ready_o = instr_ready;
    assign bus.ImmSrc        = (state_q == HOLD) ? dec_imm_src : 3'b000;
    assign bus.illegal_o     = (state_q == TRAP);
    assign bus.ctrl_valid_o  = ctrl_valid_q;
    assign bus.RegWriteE     = reg_write_q;
    assign bus.MemWriteE     = mem_write_q;
    assign bus.ALUSrcE       = alu_src_q;
    assign bus.BranchE       = branch_q;
    assign bus.JumpE         = jump_q;
    assign bus.ResultSrcE    = result_src_q;
    assign bus.ImmSrcE       = imm_src_q;
    assign bus.Rs1E          = rs1_q;
    assign bus.Rs2E          = rs2_q;
    assign bus.RdE           = rd_q;

endmodule

// File: tb/tb_id_ctrl_sequencer.sv
// Directed bench for id_ctrl_sequencer with a scoreboard of expected
// ID/EX bundles, pushed when a word is accepted and popped when EX consumes.
module tb_id_ctrl_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ctrl_sequencer_if bus ();

    id_ctrl_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] W_ADDI  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] W_SW    = 32'h00112223; // sw x1,4(x2)
    localparam logic [31:0] W_BEQ   = 32'h00000463; // beq x0,x0,8
    localparam logic [31:0] W_LW5   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] W_ADD   = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] W_LW0   = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] W_ADD0  = 32'h00700333; // add x6,x0,x7
    localparam logic [31:0] W_LUI   = 32'h123452B7; // lui x5
    localparam logic [31:0] W_JAL   = 32'h008000EF; // jal x1,8
    localparam logic [31:0] W_JALR  = 32'h000080E7; // jalr x1,0(x1)
    localparam logic [31:0] W_AUIPC = 32'h00000297; // auipc x5,0
    localparam logic [31:0] W_ILL   = 32'h0000007F;

    typedef struct {
        logic [31:0] w;
        logic [9:0]  ctrl;
    } exp_t;

    exp_t exp_q[$];
    bit   vhist[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // {legal, ImmSrc[2:0], RegWrite, MemWrite, ALUSrc, Branch, Jump, ResultSrc[1:0]}
    function automatic logic [10:0] model(input logic [31:0] w);
        case (w[6:0])
            7'b0000011: return {1'b1, 10'b000_1_0_1_0_0_01};
            7'b0010011: return {1'b1, 10'b000_1_0_1_0_0_00};
            7'b1100111: return {1'b1, 10'b000_1_0_1_0_1_10};
            7'b0100011: return {1'b1, 10'b001_0_1_1_0_0_00};
            7'b1100011: return {1'b1, 10'b010_0_0_0_1_0_00};
            7'b1101111: return {1'b1, 10'b100_1_0_0_0_1_10};
            7'b0110111: return {1'b1, 10'b101_1_0_1_0_0_00};
            7'b0010111: return {1'b1, 10'b101_1_0_1_0_0_00};
            7'b0110011: return {1'b1, 10'b000_1_0_0_0_0_00};
            default:    return 11'b0;
        endcase
    endfunction

    function automatic logic [9:0] e_ctrl();
        return {bus.ImmSrcE, bus.RegWriteE, bus.MemWriteE, bus.ALUSrcE,
                bus.BranchE, bus.JumpE, bus.ResultSrcE};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] w);
        logic [10:0] m;
        m = model(w);
        if (m[10]) exp_q.push_back('{w: w, ctrl: m[9:0]});
    endtask

    // Offer a word until accepted (bounded); returns just after the accepting edge
    task automatic send(input logic [31:0] w);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        bus.instr_i = w;
        bus.instr_valid_i = 1'b1;
        while (!done && n < 20) begin
            @(negedge clk);
            if (bus.instr_ready_o) begin
                push_exp(w);
                done = 1'b1;
            end
            tick();
            n++;
        end
        bus.instr_valid_i = 1'b0;
        chk("send_accept", 32'(done), 32'd1);
    endtask

    function automatic void hist_stats(output int ones, output int gap);
        int f;
        int l;
        f = -1;
        l = -1;
        ones = 0;
        foreach (vhist[i]) begin
            if (vhist[i]) begin
                ones++;
                if (f < 0) f = i;
                l = i;
            end
        end
        gap = (f < 0) ? 0 : (l - f + 1 - ones);
    endfunction

    // EX-side observer: bubbles must be all-zero; consumed entries must match
    task automatic monitor();
        exp_t e;
        logic [31:0] w;
        logic u1, u2, urd;
        forever begin
            @(negedge clk);
            vhist.push_back(bus.ctrl_valid_o);
            if (rst_n && !bus.ctrl_valid_o)
                chk("bubble_zero", {7'd0, e_ctrl(), bus.Rs1E, bus.Rs2E, bus.RdE}, 32'd0);
            if (rst_n && bus.ctrl_valid_o && bus.ctrl_ready_i && !bus.flush_i) begin
                chk("issue_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    w = e.w;
                    u1  = !(w[6:0] == 7'b0110111 || w[6:0] == 7'b0010111 || w[6:0] == 7'b1101111);
                    u2  = (w[6:0] == 7'b0110011 || w[6:0] == 7'b0100011 || w[6:0] == 7'b1100011);
                    urd = e.ctrl[6];
                    $display("issue word=%08h ctrl=%03h expected=%03h", w, e_ctrl(), e.ctrl);
                    chk("ctrl_bundle", 32'(e_ctrl()), 32'(e.ctrl));
                    chk("reg_fields",
                        32'({u1 ? bus.Rs1E : 5'd0, u2 ? bus.Rs2E : 5'd0, urd ? bus.RdE : 5'd0}),
                        32'({u1 ? w[19:15] : 5'd0, u2 ? w[24:20] : 5'd0, urd ? w[11:7] : 5'd0}));
                end
            end
        end
    endtask

    initial begin
        int ones;
        int gap;
        bus.instr_i       = '0;
        bus.instr_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        bus.ctrl_ready_i  = 1'b0;
        fork
            monitor();
        join_none

        // Power-on reset
        #2;
        chk("rst_instr_ready", 32'(bus.instr_ready_o), 32'd0);
        chk("rst_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
        chk("rst_immsrc", 32'(bus.ImmSrc), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.instr_ready_o), 32'd1);
        chk("post_rst_immsrc", 32'(bus.ImmSrc), 32'd0);

        // Streaming addi / sw / beq at one per cycle
        bus.ctrl_ready_i = 1'b1;
        tick();
        vhist.delete();
        bus.instr_i = W_ADDI;
        bus.instr_valid_i = 1'b1;
        @(negedge clk);
        chk("stream_ready0", 32'(bus.instr_ready_o), 32'd1);
        push_exp(W_ADDI);
        tick();
        bus.instr_i = W_SW;
        @(negedge clk);
        chk("stream_imm_addi", 32'(bus.ImmSrc), 32'd0);
        chk("stream_ready1", 32'(bus.instr_ready_o), 32'd1);
        push_exp(W_SW);
        tick();
        bus.instr_i = W_BEQ;
        @(negedge clk);
        chk("stream_imm_sw", 32'(bus.ImmSrc), 32'd1);
        chk("stream_ready2", 32'(bus.instr_ready_o), 32'd1);
        push_exp(W_BEQ);
        tick();
        bus.instr_valid_i = 1'b0;
        @(negedge clk);
        chk("stream_imm_beq", 32'(bus.ImmSrc), 32'd2);
        repeat (4) tick();
        hist_stats(ones, gap);
        chk("stream_valid_count", 32'(ones), 32'd3);
        chk("stream_valid_gap", 32'(gap), 32'd0);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Load-use on x5: exactly one bubble
        vhist.delete();
        send(W_LW5);
        send(W_ADD);
        repeat (5) tick();
        hist_stats(ones, gap);
        chk("loaduse_count", 32'(ones), 32'd2);
        chk("loaduse_bubbles", 32'(gap), 32'd1);
        chk("loaduse_drained", 32'(exp_q.size()), 32'd0);

        // Load to x0 followed by a reader of x0: no bubble
        vhist.delete();
        send(W_LW0);
        send(W_ADD0);
        repeat (5) tick();
        hist_stats(ones, gap);
        chk("x0_count", 32'(ones), 32'd2);
        chk("x0_bubbles", 32'(gap), 32'd0);
        chk("x0_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: E holds lui, D holds jal, EX stalled for 3 cycles
        bus.ctrl_ready_i = 1'b0;
        send(W_LUI);
        send(W_JAL);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.ctrl_valid_o), 32'd1);
            chk("bp_ctrl_stable", 32'(e_ctrl()), 32'(model(W_LUI) & 11'h3FF));
            chk("bp_rd_stable", 32'(bus.RdE), 32'd5);
            chk("bp_ready_low", 32'(bus.instr_ready_o), 32'd0);
            chk("bp_immsrc_jal", 32'(bus.ImmSrc), 32'd4);
            tick();
        end
        bus.ctrl_ready_i = 1'b1;
        send(W_JALR);
        send(W_AUIPC);
        repeat (4) tick();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Illegal opcode: TRAP after two edges, exit only via flush
        send(W_ILL);
        @(negedge clk);
        chk("ill_not_yet", 32'(bus.illegal_o), 32'd0);
        tick();
        @(negedge clk);
        chk("ill_trap", 32'(bus.illegal_o), 32'd1);
        chk("ill_ready_low", 32'(bus.instr_ready_o), 32'd0);
        chk("ill_drained", 32'(bus.ctrl_valid_o), 32'd0);
        tick();
        bus.instr_i = W_ADDI;
        bus.instr_valid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("trap_blocks", 32'(bus.instr_ready_o), 32'd0);
            chk("trap_held", 32'(bus.illegal_o), 32'd1);
            tick();
        end
        bus.instr_valid_i = 1'b0;
        bus.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 32'(bus.instr_ready_o), 32'd0);
        tick();
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("trap_exit", 32'(bus.illegal_o), 32'd0);
        chk("trap_exit_ready", 32'(bus.instr_ready_o), 32'd1);

        // Flush with D held, ID/EX valid and a word on offer
        tick();
        bus.ctrl_ready_i = 1'b0;
        send(W_ADDI);
        send(W_SW);
        bus.instr_i = W_BEQ;
        bus.instr_valid_i = 1'b1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_no_accept", 32'(bus.instr_ready_o), 32'd0);
        tick();
        bus.flush_i = 1'b0;
        bus.instr_valid_i = 1'b0;
        exp_q.delete();
        vhist.delete();
        @(negedge clk);
        chk("flush_valid", 32'(bus.ctrl_valid_o), 32'd0);
        chk("flush_idle_imm", 32'(bus.ImmSrc), 32'd0);
        chk("flush_idle_ready", 32'(bus.instr_ready_o), 32'd1);
        bus.ctrl_ready_i = 1'b1;
        repeat (3) tick();
        hist_stats(ones, gap);
        chk("flush_nothing_issued", 32'(ones), 32'd0);

        // Flush during a load-use hazard clears both stages
        send(W_LW5);
        send(W_ADD);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        exp_q.delete();
        vhist.delete();
        repeat (3) tick();
        hist_stats(ones, gap);
        chk("flush_hazard_clear", 32'(ones), 32'd0);

        // Reset asserted while ID/EX holds a valid entry
        bus.ctrl_ready_i = 1'b0;
        send(W_ADDI);
        tick();
        @(negedge clk);
        chk("midrst_pre_valid", 32'(bus.ctrl_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.ctrl_valid_o), 32'd0);
        chk("midrst_ctrl", 32'(e_ctrl()), 32'd0);
        chk("midrst_ready", 32'(bus.instr_ready_o), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", 32'(bus.instr_ready_o), 32'd1);
        chk("midrst_release_imm", 32'(bus.ImmSrc), 32'd0);
        chk("midrst_release_valid", 32'(bus.ctrl_valid_o), 32'd0);

        // Normal operation resumes after reset
        tick();
        bus.ctrl_ready_i = 1'b1;
        send(W_JAL);
        repeat (3) tick();
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
